// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory responder: fixed-latency load/store with stall/ack handshake.
// Replaces the zero-latency data memory between EX/MEM and MEM/WB.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        mem_stall,
    output logic        ack,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAST = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          load_q, load_d;
    logic          store_q, store_d;
    logic          bad_q, bad_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          req;
    logic [AW-1:0] live_idx;
    logic          live_bad;
    logic          fill;
    logic [AW-1:0] fill_idx;
    logic          fill_load;
    logic          fill_bad;
    logic          unused_addr;

    assign req         = mem_read | mem_write;
    assign live_idx    = address[AW+1:2];
    assign live_bad    = (address[1:0] != 2'b00) | (mem_read & mem_write);
    assign unused_addr = ^address[31:AW+2];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        load_d    = load_q;
        store_d   = store_q;
        bad_d     = bad_q;
        rdata_d   = rdata_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        fill      = 1'b0;
        fill_idx  = idx_q;
        fill_load = load_q;
        fill_bad  = bad_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = live_idx;
                    wdata_d = write_data;
                    load_d  = mem_read;
                    store_d = mem_write;
                    bad_d   = live_bad;
                    cnt_d   = 4'd1;
                    // single-cycle latency resolves straight from the live request
                    if (LATENCY == 1) begin
                        state_d   = DONE;
                        fill      = 1'b1;
                        fill_idx  = live_idx;
                        fill_load = mem_read;
                        fill_bad  = live_bad;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        fill    = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (fill) begin
            ack_d = 1'b1;
            err_d = fill_bad;
            if (fill_bad) begin
                rdata_d = '0;
            end else if (fill_load) begin
                rdata_d = mem_q[fill_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            bad_q   <= 1'b0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            store_q <= store_d;
            bad_q   <= bad_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // stores commit on the edge that ends the ack cycle
    always_ff @(posedge clk) begin
        if (!reset && state_q == DONE && store_q && !bad_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign read_data = rdata_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign mem_stall = !reset & ((state_q == IDLE & req) | state_q == BUSY);

endmodule
